pipe_front_regs: RTL and testbench
==================================

Name: pipe_front_regs

Overview:
- Implements the sequential side of the hazard protocol: the PC register, the F/D pipeline register and the D/E pipeline register of the 5-stage MIPS core.
- Consumes Stall_F, Stall_D, Flush_D, Flush_E and waiting from the hazard unit.
- Returns the decode-stage fields (Opcode_D, Funct_D, Rs_D, Rt_D) that the hazard unit evaluates.
- Keeps saturating performance counters for stall, bubble and issue cycles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 12, width of the packed decode-control bundle carried D->E.
- CNT_W, 16, width of each performance counter (saturating).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PC_Next_F  in  32  next-PC value selected by the PC_Src mux.
- Instr_F  in  32  instruction word fetched at PC_F.
- Stall_F  in  1  hold the PC register.
- Stall_D  in  1  hold the F/D register.
- Flush_D  in  1  load a bubble into the F/D register.
- Flush_E  in  1  load a bubble into the D/E register.
- waiting  in  1  multi-cycle dependency wait; freezes PC and F/D, bubbles E.
- Ctrl_D  in  CTRL_W  control bundle decoded from Instr_D.
- RD1_D, RD2_D  in  32 each  register-file read data in D.
- PC_F  out  32  current fetch PC.
- Instr_D, PCPlus4_D  out  32 each  F/D register contents.
- Valid_D  out  1  F/D holds a real instruction.
- Opcode_D, Funct_D  out  6 each  Instr_D[31:26], Instr_D[5:0].
- Rs_D, Rt_D  out  5 each  Instr_D[25:21], Instr_D[20:16].
- Ctrl_E  out  CTRL_W  D/E control bundle.
- RD1_E, RD2_E  out  32 each  D/E operand registers.
- Rs_E, Rt_E  out  5 each  D/E source register numbers.
- Valid_E  out  1  D/E holds a real instruction.
- StallCnt, FlushCnt, IssueCnt  out  CNT_W each  performance counters.

Behaviour:
- Reset, asynchronous and active-low:
  - PC_F=RESET_PC.
  - Instr_D=0, PCPlus4_D=0, Valid_D=0.
  - Ctrl_E=0, RD1_E=0, RD2_E=0, Rs_E=0, Rt_E=0, Valid_E=0.
  - All counters 0.
- Reset asserted mid-operation discards all in-flight state immediately. The first fetch after release is at RESET_PC.
- Effective controls:
  - hold_F = Stall_F | waiting.
  - hold_D = Stall_D | waiting.
  - bubble_E = Flush_E | waiting.
- PC register:
  - if !hold_F, PC_F <= PC_Next_F; else PC_F is held.
  - Latency from PC_Next_F to PC_F is one cycle.
- F/D register, priority hold_D > Flush_D > load:
  - hold_D: all fields held.
  - else Flush_D: Instr_D<=0 (nop), PCPlus4_D<=0, Valid_D<=0.
  - else: Instr_D<=Instr_F, PCPlus4_D<=PC_F+4 (mod 2^32, wraps at 32'hFFFF_FFFC), Valid_D<=1.
- Simultaneous Stall_D and Flush_D: the stall wins and the instruction in D is preserved. Flush_D is re-evaluated on the next un-stalled cycle.
- D/E register, priority bubble_E > load:
  - bubble_E: Ctrl_E<=0, Valid_E<=0, Rs_E<=0, Rt_E<=0; RD1_E and RD2_E are don't-care and are driven 0.
  - else: Ctrl_E<=Valid_D ? Ctrl_D : 0; Valid_E<=Valid_D; RD1_E, RD2_E, Rs_E, Rt_E load from D.
- Field outputs Opcode_D, Funct_D, Rs_D and Rt_D are purely combinational from Instr_D, with zero latency to the hazard unit.
- Counters: each increments by 1 per cycle and saturates at all-ones (no wrap).
  - StallCnt: cycles with hold_D=1.
  - FlushCnt: cycles with Flush_D=1 or Flush_E=1; counted once per cycle even when both are asserted.
  - IssueCnt: cycles in which D/E loads with Valid_D=1 and bubble_E=0.
- A held F/D combined with a bubbled E is the required load-use response: the instruction in D re-enters E on the first cycle after the stall drops.

Test Plan:
- Reset release with PC_Next_F=PC_F+4 and no hazards -> PC_F = 0, 4, 8 on successive cycles. Valid_D=1 from cycle 2, Valid_E=1 from cycle 3. IssueCnt=1 after cycle 3.
- Load-use: Stall_F=Stall_D=Flush_E=1 for one cycle with Instr_D=32'h8C22_0004 -> PC_F and Instr_D held, Valid_E=0, Ctrl_E=0, StallCnt=1. On the next cycle E receives Rs_E=1, Rt_E=2.
- Jump: Flush_D=1 with PC_Next_F=32'h0040_0100 -> next cycle PC_F=32'h0040_0100, Instr_D=0, Valid_D=0, FlushCnt=1.
- Stall_D and Flush_D both asserted -> Instr_D unchanged, Valid_D=1. The following cycle with Flush_D=1 alone clears it.
- waiting held for 3 cycles -> PC_F and Instr_D frozen, Valid_E=0 for all 3 cycles, StallCnt=3. Ctrl_E=Ctrl_D and Valid_E=1 on the 4th cycle.
- CNT_W=4 with 20 continuous stall cycles -> StallCnt saturates at 4'hF. RESET_N pulsed low mid-run -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_front_regs.sv
// PC register, F/D and D/E pipeline registers of the 5-stage MIPS core,
// driven by the hazard unit. Also holds the saturating stall/flush/issue counters.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       PC_Next_F,
    input  logic [31:0]       Instr_F,
    input  logic              Stall_F,
    input  logic              Stall_D,
    input  logic              Flush_D,
    input  logic              Flush_E,
    input  logic              waiting,
    input  logic [CTRL_W-1:0] Ctrl_D,
    input  logic [31:0]       RD1_D,
    input  logic [31:0]       RD2_D,
    output logic [31:0]       PC_F,
    output logic [31:0]       Instr_D,
    output logic [31:0]       PCPlus4_D,
    output logic              Valid_D,
    output logic [5:0]        Opcode_D,
    output logic [5:0]        Funct_D,
    output logic [4:0]        Rs_D,
    output logic [4:0]        Rt_D,
    output logic [CTRL_W-1:0] Ctrl_E,
    output logic [31:0]       RD1_E,
    output logic [31:0]       RD2_E,
    output logic [4:0]        Rs_E,
    output logic [4:0]        Rt_E,
    output logic              Valid_E,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic [CNT_W-1:0]  IssueCnt
);

    // A multi-cycle wait acts as a stall on F and D plus a bubble into E.
    logic hold_f, hold_d, bubble_e;
    assign hold_f   = Stall_F | waiting;
    assign hold_d   = Stall_D | waiting;
    assign bubble_e = Flush_E | waiting;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d, pc4_q, pc4_d;
    logic              vd_q, vd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       rd1_q, rd1_d, rd2_q, rd2_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d;
    logic              ve_q, ve_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

    // Next-state for PC, F/D (hold > flush > load) and D/E (bubble > load).
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        vd_d    = vd_q;
        ctrl_d  = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        ve_d    = 1'b0;

        if (!hold_f) pc_d = PC_Next_F;

        if (!hold_d) begin
            if (Flush_D) begin
                instr_d = '0;
                pc4_d   = '0;
                vd_d    = 1'b0;
            end else begin
                instr_d = Instr_F;
                pc4_d   = pc_q + 32'd4;
                vd_d    = 1'b1;
            end
        end

        if (!bubble_e) begin
            ctrl_d = vd_q ? Ctrl_D : '0;
            ve_d   = vd_q;
            rd1_d  = RD1_D;
            rd2_d  = RD2_D;
            rs_d   = instr_q[25:21];
            rt_d   = instr_q[20:16];
        end
    end

    // Saturating counters: stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (hold_d && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((Flush_D || Flush_E) && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (!bubble_e && vd_q && issue_cnt_q != '1)
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    // State registers; reset drops all in-flight state immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc4_q       <= '0;
            vd_q        <= 1'b0;
            ctrl_q      <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            ve_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            vd_q        <= vd_d;
            ctrl_q      <= ctrl_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            ve_q        <= ve_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign PC_F      = pc_q;
    assign Instr_D   = instr_q;
    assign PCPlus4_D = pc4_q;
    assign Valid_D   = vd_q;
    // Decode fields go straight to the hazard unit with no register delay.
    assign Opcode_D  = instr_q[31:26];
    assign Funct_D   = instr_q[5:0];
    assign Rs_D      = instr_q[25:21];
    assign Rt_D      = instr_q[20:16];
    assign Ctrl_E    = ctrl_q;
    assign RD1_E     = rd1_q;
    assign RD2_E     = rd2_q;
    assign Rs_E      = rs_q;
    assign Rt_E      = rt_q;
    assign Valid_E   = ve_q;
    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;
    assign IssueCnt  = issue_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench: stimulus process advances a reference model and queues
// the expected state; a negedge monitor pops and compares against the DUTs.
module tb_pipe_front_regs;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] PC_Next_F, Instr_F, RD1_D, RD2_D;
    logic        Stall_F, Stall_D, Flush_D, Flush_E, waiting;
    logic [11:0] Ctrl_D;

    logic [31:0] PC_F, Instr_D, PCPlus4_D, RD1_E, RD2_E;
    logic        Valid_D, Valid_E;
    logic [5:0]  Opcode_D, Funct_D;
    logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E;
    logic [11:0] Ctrl_E;
    logic [15:0] StallCnt, FlushCnt, IssueCnt;

    // Narrow-counter instance for saturation; only its counters are checked.
    logic [31:0] s_PC_F, s_Instr_D, s_PCPlus4_D, s_RD1_E, s_RD2_E;
    logic        s_Valid_D, s_Valid_E;
    logic [5:0]  s_Opcode_D, s_Funct_D;
    logic [4:0]  s_Rs_D, s_Rt_D, s_Rs_E, s_Rt_E;
    logic [11:0] s_Ctrl_E;
    logic [3:0]  StallCnt4, FlushCnt4, IssueCnt4;

    always #5 CLK = ~CLK;

    pipe_front_regs u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .PC_Next_F(PC_Next_F), .Instr_F(Instr_F),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .waiting(waiting), .Ctrl_D(Ctrl_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .PC_F(PC_F), .Instr_D(Instr_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D),
        .Opcode_D(Opcode_D), .Funct_D(Funct_D), .Rs_D(Rs_D), .Rt_D(Rt_D),
        .Ctrl_E(Ctrl_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .Valid_E(Valid_E), .StallCnt(StallCnt), .FlushCnt(FlushCnt), .IssueCnt(IssueCnt)
    );

    pipe_front_regs #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .PC_Next_F(PC_Next_F), .Instr_F(Instr_F),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .waiting(waiting), .Ctrl_D(Ctrl_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .PC_F(s_PC_F), .Instr_D(s_Instr_D), .PCPlus4_D(s_PCPlus4_D), .Valid_D(s_Valid_D),
        .Opcode_D(s_Opcode_D), .Funct_D(s_Funct_D), .Rs_D(s_Rs_D), .Rt_D(s_Rt_D),
        .Ctrl_E(s_Ctrl_E), .RD1_E(s_RD1_E), .RD2_E(s_RD2_E), .Rs_E(s_Rs_E), .Rt_E(s_Rt_E),
        .Valid_E(s_Valid_E), .StallCnt(StallCnt4), .FlushCnt(FlushCnt4), .IssueCnt(IssueCnt4)
    );

    typedef struct {
        logic [31:0] pc, ins, pc4, rd1, rd2;
        logic        vd, ve;
        logic [11:0] ctrl;
        logic [4:0]  rs, rt;
        int          sc, fc, ic, sc4, fc4, ic4;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic int inc_sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic model_reset();
        m = '{pc: 32'h0, ins: 32'h0, pc4: 32'h0, rd1: 32'h0, rd2: 32'h0, vd: 1'b0, ve: 1'b0,
              ctrl: 12'h0, rs: 5'h0, rt: 5'h0, sc: 0, fc: 0, ic: 0, sc4: 0, fc4: 0, ic4: 0};
    endtask

    // One clock of the reference: all updates computed from the old state.
    task automatic model_step();
        exp_t o;
        bit hf, hd, be;
        o  = m;
        hf = Stall_F || waiting;
        hd = Stall_D || waiting;
        be = Flush_E || waiting;
        if (!hf) m.pc = PC_Next_F;
        if (!hd) begin
            m.ins = Flush_D ? 32'h0 : Instr_F;
            m.pc4 = Flush_D ? 32'h0 : o.pc + 32'd4;
            m.vd  = !Flush_D;
        end
        if (be) begin
            m.ctrl = 0; m.ve = 0; m.rs = 0; m.rt = 0; m.rd1 = 0; m.rd2 = 0;
        end else begin
            m.ctrl = o.vd ? Ctrl_D : 12'h0;
            m.ve   = o.vd;
            m.rd1  = RD1_D;
            m.rd2  = RD2_D;
            m.rs   = o.ins[25:21];
            m.rt   = o.ins[20:16];
        end
        if (hd) begin m.sc = inc_sat(m.sc, 65535); m.sc4 = inc_sat(m.sc4, 15); end
        if (Flush_D || Flush_E) begin m.fc = inc_sat(m.fc, 65535); m.fc4 = inc_sat(m.fc4, 15); end
        if (!be && o.vd) begin m.ic = inc_sat(m.ic, 65535); m.ic4 = inc_sat(m.ic4, 15); end
    endtask

    task automatic cyc(input logic stf, input logic std, input logic fd, input logic fe,
                       input logic w, input logic [31:0] nxt, input logic [31:0] ins);
        Stall_F = stf; Stall_D = std; Flush_D = fd; Flush_E = fe; waiting = w;
        PC_Next_F = nxt; Instr_F = ins;
        Ctrl_D = 12'($urandom); RD1_D = $urandom; RD2_D = $urandom;
        @(posedge CLK);
        model_step();
        q.push_back(m);
        #2;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, " PC_F"}, 64'(PC_F), 64'h0);
        chk({tag, " Instr_D"}, 64'(Instr_D), 64'h0);
        chk({tag, " PCPlus4_D"}, 64'(PCPlus4_D), 64'h0);
        chk({tag, " Valid_D"}, 64'(Valid_D), 64'h0);
        chk({tag, " Valid_E"}, 64'(Valid_E), 64'h0);
        chk({tag, " Ctrl_E"}, 64'(Ctrl_E), 64'h0);
        chk({tag, " RD1_E"}, 64'(RD1_E), 64'h0);
        chk({tag, " Rs_E"}, 64'(Rs_E), 64'h0);
        chk({tag, " StallCnt"}, 64'(StallCnt), 64'h0);
        chk({tag, " FlushCnt"}, 64'(FlushCnt), 64'h0);
        chk({tag, " IssueCnt"}, 64'(IssueCnt), 64'h0);
        chk({tag, " StallCnt4"}, 64'(StallCnt4), 64'h0);
    endtask

    // Monitor: outputs settle after every edge, so one expectation per cycle.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PC_F", 64'(PC_F), 64'(e.pc));
            chk("Instr_D", 64'(Instr_D), 64'(e.ins));
            chk("PCPlus4_D", 64'(PCPlus4_D), 64'(e.pc4));
            chk("Valid_D", 64'(Valid_D), 64'(e.vd));
            chk("Opcode_D", 64'(Opcode_D), 64'(e.ins[31:26]));
            chk("Funct_D", 64'(Funct_D), 64'(e.ins[5:0]));
            chk("Rs_D", 64'(Rs_D), 64'(e.ins[25:21]));
            chk("Rt_D", 64'(Rt_D), 64'(e.ins[20:16]));
            chk("Ctrl_E", 64'(Ctrl_E), 64'(e.ctrl));
            chk("RD1_E", 64'(RD1_E), 64'(e.rd1));
            chk("RD2_E", 64'(RD2_E), 64'(e.rd2));
            chk("Rs_E", 64'(Rs_E), 64'(e.rs));
            chk("Rt_E", 64'(Rt_E), 64'(e.rt));
            chk("Valid_E", 64'(Valid_E), 64'(e.ve));
            chk("StallCnt", 64'(StallCnt), 64'(e.sc));
            chk("FlushCnt", 64'(FlushCnt), 64'(e.fc));
            chk("IssueCnt", 64'(IssueCnt), 64'(e.ic));
            chk("StallCnt4", 64'(StallCnt4), 64'(e.sc4));
            chk("FlushCnt4", 64'(FlushCnt4), 64'(e.fc4));
            chk("IssueCnt4", 64'(IssueCnt4), 64'(e.ic4));
        end
    end

    task automatic rand_cyc();
        logic stf, std, fd, fe, w, jmp;
        stf = ($urandom_range(0, 5) == 0);
        std = stf | ($urandom_range(0, 7) == 0);
        fd  = ($urandom_range(0, 6) == 0);
        fe  = ($urandom_range(0, 5) == 0);
        w   = ($urandom_range(0, 9) == 0);
        jmp = ($urandom_range(0, 7) == 0);
        // Occasionally push the fetch PC to the top of memory to exercise PC+4 wrap.
        if ($urandom_range(0, 40) == 0)
            cyc(stf, std, fd, fe, w, 32'hFFFF_FFFC, $urandom);
        else
            cyc(stf, std, fd, fe, w, jmp ? {$urandom, 2'b00} : m.pc + 32'd4, $urandom);
    endtask

    initial begin
        RESET_N = 1'b0;
        Stall_F = 0; Stall_D = 0; Flush_D = 0; Flush_E = 0; waiting = 0;
        PC_Next_F = 0; Instr_F = 0; Ctrl_D = 0; RD1_D = 0; RD2_D = 0;
        model_reset();
        #3 rst_chk("reset");
        @(posedge CLK); #2 RESET_N = 1'b1;

        // Clean start: PC 0 -> 4 -> 8, D then E fill.
        repeat (3) cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        // Load-use: lw in D held one cycle while E is bubbled, then issues.
        cyc(0, 0, 0, 0, 0, m.pc + 32'd4, 32'h8C22_0004);
        cyc(1, 1, 0, 1, 0, m.pc + 32'd4, $urandom);
        cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        // Jump: redirect and squash F/D.
        cyc(0, 0, 1, 0, 0, 32'h0040_0100, $urandom);
        cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        // Stall beats flush, flush applies once unstalled.
        cyc(1, 1, 1, 0, 0, m.pc + 32'd4, $urandom);
        cyc(0, 0, 1, 0, 0, m.pc + 32'd4, $urandom);
        cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        // Multi-cycle wait, then release.
        repeat (3) cyc(0, 0, 0, 0, 1, m.pc + 32'd4, $urandom);
        repeat (2) cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        // Long stall saturates the narrow counter.
        repeat (20) cyc(1, 1, 0, 1, 0, m.pc + 32'd4, $urandom);
        repeat (300) rand_cyc();

        // Mid-run reset: outputs must clear before any clock edge.
        @(negedge CLK); #1;
        RESET_N = 1'b0;
        #1 rst_chk("async reset");
        q.delete();
        model_reset();
        @(posedge CLK); #2 RESET_N = 1'b1;
        repeat (2) cyc(0, 0, 0, 0, 0, m.pc + 32'd4, $urandom);
        repeat (200) rand_cyc();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
